// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the responder FSM and its storage array.
package dmem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;

  localparam logic [DEF_DATA_W-1:0] RESP_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read.
// Contents and read register are deliberately left unreset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, programmable
// wait states, registered response under valid/ready.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic rd_q, rd_d;
  logic err_q, err_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              access;
  logic              acc_we;
  logic              acc_in;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign accept = req_valid && (state_q == IDLE);

  // Zero-wait accesses use the live request; otherwise the latched copy.
  assign acc_we    = NO_WAIT ? req_we    : we_q;
  assign acc_addr  = NO_WAIT ? req_addr  : addr_q;
  assign acc_wdata = NO_WAIT ? req_wdata : wdata_q;
  assign acc_in    = {1'b0, acc_addr} < DEPTH_C;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (NO_WAIT) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (access) begin
      rd_d  = acc_in && !acc_we;
      err_d = !acc_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_array (
    .clk  (clk),
    .en   (access && acc_in),
    .we   (acc_we),
    .addr (acc_addr[AW-1:0]),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  // Read register is unreset, so a reset flag gates it to zero.
  assign resp_rdata = rd_q ? arr_rdata : DATA_W'(RESP_ZERO);
  assign resp_err   = err_q;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench: two responders (2 and 0 wait states)
// checked against an array-based memory model.
module tb_data_mem_responder;

  localparam int WC [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [15:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err [2];
  logic        busy [2];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_m [2][256];
  bit          known [2][256];

  typedef struct {
    bit          chk;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .busy(busy[0])
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .busy(busy[1])
  );

  // Drives one request and returns what the response showed.
  task automatic xact(input int k, input logic we,
                      input logic [15:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err,
                      output int lat, output logic rdy_after);
    int n = 0;
    while (!req_ready[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = d;
    @(posedge clk); #1;
    rdy_after    = req_ready[k];
    req_valid[k] = 1'b0;
    req_we[k]    = ~we;
    req_addr[k]  = 16'($urandom);
    req_wdata[k] = $urandom;
    lat = 0;
    while (!resp_valid[k] && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    rd  = resp_rdata[k];
    err = resp_err[k];
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({req_ready[k], resp_valid[k], resp_err[k], busy[k]} !== 4'b1000) begin
        miscompares++;
        $display("FAIL reset_flags[%0d]: got %b expected 1000", k,
                 {req_ready[k], resp_valid[k], resp_err[k], busy[k]});
      end
      vectors++;
      if (resp_rdata[k] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rdata[%0d]: got %h expected 0", k, resp_rdata[k]);
      end
    end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic err; int lat; logic ra;
    xact(0, 1'b1, 16'd5, 32'hDEADBEEF, rd, err, lat, ra);
    mem_m[0][5] = 32'hDEADBEEF; known[0][5] = 1'b1;
    vectors++;
    if (ra !== 1'b0) begin
      miscompares++;
      $display("FAIL store_ready_drop: got %b expected 0", ra);
    end
    vectors++;
    if (lat !== WC[0]) begin
      miscompares++;
      $display("FAIL store_latency: got %0d expected %0d", lat, WC[0]);
    end
    vectors++;
    if ({err, rd} !== 33'h0) begin
      miscompares++;
      $display("FAIL store_resp: got err=%b rd=%h expected err=0 rd=0", err, rd);
    end
    xact(0, 1'b0, 16'd5, $urandom, rd, err, lat, ra);
    vectors++;
    if (lat !== WC[0]) begin
      miscompares++;
      $display("FAIL load_latency: got %0d expected %0d", lat, WC[0]);
    end
    vectors++;
    if ({err, rd} !== {1'b0, mem_m[0][5]}) begin
      miscompares++;
      $display("FAIL load_data: got err=%b rd=%h expected err=0 rd=%h",
               err, rd, mem_m[0][5]);
    end
  endtask

  task automatic test_no_wait;
    logic [31:0] rd; logic err; int lat; logic ra;
    xact(1, 1'b1, 16'd0, 32'h12345678, rd, err, lat, ra);
    mem_m[1][0] = 32'h12345678; known[1][0] = 1'b1;
    vectors++;
    if (lat !== WC[1] || ra !== 1'b0) begin
      miscompares++;
      $display("FAIL w0_store_latency: got lat=%0d ready=%b expected lat=0 ready=0",
               lat, ra);
    end
    xact(1, 1'b0, 16'd0, 32'h0, rd, err, lat, ra);
    vectors++;
    if (lat !== WC[1]) begin
      miscompares++;
      $display("FAIL w0_load_latency: got %0d expected 0", lat);
    end
    vectors++;
    if ({err, rd} !== {1'b0, mem_m[1][0]}) begin
      miscompares++;
      $display("FAIL w0_load_data: got %h expected %h", rd, mem_m[1][0]);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic err; int lat; logic ra;
    logic [31:0] p;
    p = $urandom;
    xact(0, 1'b1, 16'd44, p, rd, err, lat, ra);
    mem_m[0][44] = p; known[0][44] = 1'b1;
    xact(0, 1'b1, 16'd300, 32'hFFFFFFFF, rd, err, lat, ra);
    vectors++;
    if ({err, rd} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL oor_store: got err=%b rd=%h expected err=1 rd=0", err, rd);
    end
    xact(0, 1'b0, 16'd44, 32'h0, rd, err, lat, ra);
    vectors++;
    if ({err, rd} !== {1'b0, p}) begin
      miscompares++;
      $display("FAIL oor_alias: got err=%b rd=%h expected err=0 rd=%h", err, rd, p);
    end
    xact(0, 1'b0, 16'hFFFF, 32'h0, rd, err, lat, ra);
    vectors++;
    if ({err, rd} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL oor_load: got err=%b rd=%h expected err=1 rd=0", err, rd);
    end
    xact(1, 1'b1, 16'd256, 32'hCAFEF00D, rd, err, lat, ra);
    vectors++;
    if ({err, rd} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL w0_oor_store: got err=%b rd=%h expected err=1 rd=0", err, rd);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic err; int lat; logic ra;
    logic [31:0] exp_rd;
    int n = 0;
    exp_rd = mem_m[0][5];
    req_valid[0] = 1'b1; req_we[0] = 1'b0;
    req_addr[0] = 16'd5; req_wdata[0] = 32'h0;
    @(posedge clk); #1;
    // A competing store that must not be taken while busy.
    req_we[0] = 1'b1;
    while (!resp_valid[0] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({resp_valid[0], req_ready[0], resp_err[0], resp_rdata[0]} !==
          {1'b1, 1'b0, 1'b0, exp_rd}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b rdy=%b err=%b rd=%h expected v=1 rdy=0 err=0 rd=%h",
                 i, resp_valid[0], req_ready[0], resp_err[0], resp_rdata[0], exp_rd);
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    vectors++;
    if ({resp_valid[0], req_ready[0], resp_rdata[0]} !== {1'b0, 1'b1, exp_rd}) begin
      miscompares++;
      $display("FAIL bp_release: got v=%b rdy=%b rd=%h expected v=0 rdy=1 rd=%h",
               resp_valid[0], req_ready[0], resp_rdata[0], exp_rd);
    end
    xact(0, 1'b0, 16'd5, 32'h0, rd, err, lat, ra);
    vectors++;
    if (rd !== exp_rd) begin
      miscompares++;
      $display("FAIL bp_no_accept: got %h expected %h", rd, exp_rd);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] rd; logic err; int lat; logic ra;
    int n = 0;
    xact(0, 1'b1, 16'd7, 32'h11111111, rd, err, lat, ra);
    mem_m[0][7] = 32'h11111111; known[0][7] = 1'b1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1;
    req_addr[0] = 16'd7; req_wdata[0] = 32'hAAAA5555;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready[0], resp_valid[0], resp_err[0], busy[0], resp_rdata[0]} !==
        {4'b1000, 32'h0}) begin
      miscompares++;
      $display("FAIL rst_wait_async: got rdy=%b v=%b err=%b busy=%b rd=%h expected 1 0 0 0 0",
               req_ready[0], resp_valid[0], resp_err[0], busy[0], resp_rdata[0]);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    xact(0, 1'b0, 16'd7, 32'h0, rd, err, lat, ra);
    vectors++;
    if (rd !== mem_m[0][7]) begin
      miscompares++;
      $display("FAIL rst_wait_mem: got %h expected %h", rd, mem_m[0][7]);
    end
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'd5;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    while (!resp_valid[0] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (resp_rdata[0] !== mem_m[0][5]) begin
      miscompares++;
      $display("FAIL rst_resp_pre: got %h expected %h", resp_rdata[0], mem_m[0][5]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({resp_valid[0], req_ready[0], resp_rdata[0]} !== {2'b01, 32'h0}) begin
      miscompares++;
      $display("FAIL rst_resp_drop: got v=%b rdy=%b rd=%h expected v=0 rdy=1 rd=0",
               resp_valid[0], req_ready[0], resp_rdata[0]);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    exp_t q[$];
    exp_t e;
    int cyc = 0, acc = 0, rsp = 0;
    bit lat_done = 1'b0;
    logic we; logic [15:0] a; logic [31:0] d; bit oor;
    while (rsp < 20 && cyc < 2000) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) a = 16'(256 + $urandom_range(0, 1000));
      else a = 16'($urandom_range(0, 7));
      d = $urandom;
      req_valid[0] = 1'b1; req_we[0] = we;
      req_addr[0] = a; req_wdata[0] = d;
      resp_ready[0] = 1'($urandom_range(0, 1));
      vectors++;
      if (busy[0] !== !req_ready[0]) begin
        miscompares++;
        $display("FAIL b2b_busy: got busy=%b expected %b", busy[0], !req_ready[0]);
      end
      if (req_ready[0]) begin
        vectors++;
        if (q.size() != 0 || resp_valid[0]) begin
          miscompares++;
          $display("FAIL b2b_overlap: got pending=%0d expected 0", q.size());
        end
        oor = (a >= 16'd256);
        e.err = oor;
        e.cyc = cyc;
        if (we || oor) begin
          e.chk = 1'b1; e.rd = 32'h0;
        end else begin
          e.chk = known[0][a[7:0]]; e.rd = mem_m[0][a[7:0]];
        end
        if (we && !oor) begin
          mem_m[0][a[7:0]] = d; known[0][a[7:0]] = 1'b1;
        end
        q.push_back(e);
        acc++;
      end
      if (resp_valid[0]) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_spurious: got response expected none");
        end else begin
          if (!lat_done) begin
            lat_done = 1'b1;
            vectors++;
            if (cyc - q[0].cyc !== WC[0] + 1) begin
              miscompares++;
              $display("FAIL b2b_latency: got %0d expected %0d",
                       cyc - q[0].cyc - 1, WC[0]);
            end
          end
          if (resp_ready[0]) begin
            vectors++;
            if (resp_err[0] !== q[0].err ||
                (q[0].chk && resp_rdata[0] !== q[0].rd)) begin
              miscompares++;
              $display("FAIL b2b_resp: got err=%b rd=%h expected err=%b rd=%h",
                       resp_err[0], resp_rdata[0], q[0].err, q[0].rd);
            end
            void'(q.pop_front());
            rsp++;
            lat_done = 1'b0;
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b0;
    vectors++;
    if (rsp !== 20 || acc !== rsp || q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_count: got acc=%0d rsp=%0d expected 20 20", acc, rsp);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_addr[k] = 16'h0; req_wdata[k] = 32'h0;
      resp_ready[k] = 1'b0;
    end
    #12;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_store_load();
    test_no_wait();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
